// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the iterative right-shift unit.
//   shr_state_e : control FSM states of shift_right_seq
//   XLEN        : native datapath width of the execute stage
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_e;

endpackage : shift_pkg

// File: rtl/shift_right_step.sv
// ---------------------------------------------------------------------------
// shift_right_step
// Combinational single-step right shifter. Shifts data_i right by
// amount_i (0..STEP) positions and fills the vacated MSBs with fill_i.
// Driving fill_i with the operand MSB gives an arithmetic shift; driving
// it with 0 gives a logical shift.
//   data_i   : operand
//   amount_i : shift distance for this step, 0..STEP
//   fill_i   : bit copied into the vacated MSBs
//   data_o   : shifted operand
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module shift_right_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o
);

  // Prepending the fill bit as a sign bit lets a single arithmetic shift
  // serve both shift kinds: the fill bit replicates into every vacated MSB.
  logic signed [WIDTH:0] ext;

  assign ext    = {fill_i, data_i};
  assign data_o = WIDTH'(ext >>> amount_i);

endmodule : shift_right_step

// File: rtl/shift_right_seq.sv
// ---------------------------------------------------------------------------
// shift_right_seq
// Multi-cycle iterative right shifter (SRL/SRLI/SRA/SRAI). Shifts by at most
// STEP bit positions per clock until the requested amount is consumed.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   valid_i  : request valid
//   ready_o  : unit idle and able to accept a request
//   data_i   : operand
//   shamt_i  : shift amount (only the low SHW bits exist, i.e. mod WIDTH)
//   arith_i  : 1 = arithmetic (sign fill), 0 = logical (zero fill)
//   valid_o  : result valid, held until ready_i
//   ready_i  : consumer accepts result
//   result_o : shifted result, meaningful only while valid_o=1
// A request accepted in IDLE produces valid_o max(1, ceil(shamt/STEP))
// cycles after the accepting edge. After the result handshake the unit
// spends one cycle in IDLE before it can accept again.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic             arith_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int          AMT_W  = $clog2(STEP + 1);
  localparam logic [31:0] STEP_U = 32'(STEP);

  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("shift_right_seq: STEP must lie in 1..WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("shift_right_seq: WIDTH must be at least 2");
  end

  shr_state_e       state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   rem_q,   rem_d;
  logic             arith_q, arith_d;

  logic             last_step;
  logic [AMT_W-1:0] step_amt;
  logic             fill_bit;
  logic [WIDTH-1:0] work_shifted;

  // The final step is the one that consumes everything left; this also
  // covers rem=0, which still spends one cycle in SHIFT.
  assign last_step = (32'(rem_q) <= STEP_U);
  assign step_amt  = last_step ? AMT_W'(rem_q) : AMT_W'(STEP);

  // Re-sampling the current MSB each step is equivalent to using the
  // original sign bit, because an arithmetic step never changes the MSB.
  assign fill_bit  = arith_q & work_q[WIDTH-1];

  shift_right_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AMT_W (AMT_W)
  ) u_step (
    .data_i   (work_q),
    .amount_i (step_amt),
    .fill_i   (fill_bit),
    .data_o   (work_shifted)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    arith_d = arith_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          work_d  = data_i;
          rem_d   = shamt_i;
          arith_d = arith_i;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        work_d = work_shifted;
        rem_d  = rem_q - SHW'(step_amt);
        if (last_step) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // Everything holds until the consumer takes the result.
        if (ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // work_q is reset as well so that result_o reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      arith_q <= arith_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = work_q;

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
`timescale 1ns/1ps
module tb_shift_right_seq;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        arith_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  int errors;
  int checks;

  shift_right_seq #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .shamt_i  (shamt_i),
    .arith_i  (arith_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics, not the iteration.
  function automatic logic [31:0] model_res(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  function automatic int model_lat(input logic [4:0] s);
    int n;
    n = (int'(s) + 3) / 4;
    return (n < 1) ? 1 : n;
  endfunction

  // Issues one request (unit assumed able to accept soon), measures the
  // latency to valid_o, then completes the output handshake. With rnd set,
  // ready_i is randomised while the result is pending and stability is checked.
  task automatic do_req(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input bit rnd, output logic [31:0] res, output int lat);
    int  n;
    bit  took;
    n = 0;
    while (!ready_o && n < 64) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!ready_o) begin
      check("wait_ready_o", 32'(ready_o), 32'd1);
    end
    data_i  = d;
    shamt_i = s;
    arith_i = a;
    valid_i = 1'b1;
    ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    data_i  = $urandom;
    shamt_i = 5'($urandom_range(0, 31));
    arith_i = 1'($urandom_range(0, 1));
    lat = 0;
    res = '0;
    while (lat < 64) begin
      @(posedge clk_i); #1;
      lat++;
      if (valid_o) break;
    end
    if (!valid_o) begin
      lat = -1;
      return;
    end
    res = result_o;
    check("ready_o_low_in_done", 32'(ready_o), 32'd0);
    n    = 0;
    took = 1'b0;
    while (!took) begin
      ready_i = (rnd && n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_i); #1;
      if (ready_i) begin
        took = 1'b1;
      end else begin
        check("hold_valid_o", 32'(valid_o), 32'd1);
        check("hold_result_o", result_o, res);
      end
      n++;
    end
    ready_i = 1'b0;
    check("ready_o_after_handshake", 32'(ready_o), 32'd1);
    check("valid_o_after_handshake", 32'(valid_o), 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vecs[9];
    logic [31:0] res;
    int          lat;
    logic [31:0] d;
    logic [4:0]  s;
    logic        a;

    errors  = 0;
    checks  = 0;
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    shamt_i = '0;
    arith_i = 1'b0;

    vecs[0] = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F, 1};
    vecs[1] = '{32'h8000_00F0, 5'd4,  1'b1, 32'hF800_000F, 1};
    vecs[2] = '{32'h8000_00F0, 5'd5,  1'b1, 32'hFC00_0007, 2};
    vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1};
    vecs[4] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 8};
    vecs[5] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 8};
    vecs[6] = '{32'h8000_0000, 5'd8,  1'b1, 32'hFF80_0000, 2};
    vecs[7] = '{32'hF000_0000, 5'd1,  1'b1, 32'hF800_0000, 1};
    vecs[8] = '{32'h7FFF_FFFF, 5'd9,  1'b1, 32'h003F_FFFF, 3};

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ready_o", 32'(ready_o), 32'd1);
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_result_o", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].data, vecs[i].shamt, vecs[i].arith, 1'b0, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: result held for 3 cycles, a valid_i pulse is ignored
    ready_i = 1'b0;
    data_i  = 32'h8000_00F0;
    shamt_i = 5'd4;
    arith_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("bp_valid_o_first", 32'(valid_o), 32'd1);
    check("bp_result_first", result_o, 32'hF800_000F);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        valid_i = 1'b1;
        data_i  = 32'h0000_1111;
        shamt_i = 5'd0;
        arith_i = 1'b0;
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      check("bp_valid_o_hold", 32'(valid_o), 32'd1);
      check("bp_result_hold", result_o, 32'hF800_000F);
      check("bp_ready_o_low", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    check("bp_ready_o_release", 32'(ready_o), 32'd1);
    check("bp_valid_o_release", 32'(valid_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("bp_pulse_not_queued_valid", 32'(valid_o), 32'd0);
    check("bp_pulse_not_queued_ready", 32'(ready_o), 32'd1);

    // Reset in the middle of a long shift
    data_i  = 32'h8000_0000;
    shamt_i = 5'd31;
    arith_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check("mid_shift_busy", 32'(ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    check("mid_reset_valid_o", 32'(valid_o), 32'd0);
    check("mid_reset_result_o", result_o, 32'd0);
    check("mid_reset_ready_o", 32'(ready_o), 32'd1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("post_reset_ready_o", 32'(ready_o), 32'd1);
    repeat (10) @(posedge clk_i);
    #1;
    check("aborted_no_result", 32'(valid_o), 32'd0);
    do_req(32'hFFFF_0000, 5'd16, 1'b0, 1'b0, res, lat);
    check("post_reset_result", res, 32'h0000_FFFF);
    check("post_reset_latency", 32'(lat), 32'd4);

    // Random back-to-back requests with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      a = 1'($urandom_range(0, 1));
      if (i < 4) d[31] = 1'b1;
      do_req(d, s, a, 1'b1, res, lat);
      check($sformatf("rand%0d_result d=%08h s=%0d a=%0d", i, d, s, a), res, model_res(d, s, a));
      check($sformatf("rand%0d_latency s=%0d", i, s), 32'(lat), 32'(model_lat(s)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_shift_right_seq

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle iterative right shifter: the counterpart of the combinational left shifter in the execute datapath.
- Performs logical (SRL/SRLI) and arithmetic (SRA/SRAI) right shifts, STEP bit positions per cycle.
- Uses valid/ready handshakes on both input and output.
- Sits beside the ALU as a low-area shift unit. The issue stage stalls on ready_o.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STEP, 4, maximum bit positions shifted per cycle (1..WIDTH).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- data_i  input  WIDTH  operand to shift.
- shamt_i  input  SHW  shift amount 0..WIDTH-1.
- arith_i  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  shifted result.

Behaviour:
- Clock and reset (already decided): one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE, ready_o=1, valid_o=0, result_o=0, remaining count=0, arith flag=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o at an edge: latch data_i into the work register, shamt_i into rem, arith_i into the flag; go to SHIFT.
- SHIFT:
  - ready_o=0, valid_o=0.
  - Each cycle: step=min(rem,STEP); work <= work >> step, with vacated MSBs filled with work[WIDTH-1] if arith else 0; rem <= rem-step.
  - When rem<=STEP (includes rem=0), go to DONE at the same edge, with the final shift applied.
- DONE:
  - valid_o=1; result_o=work.
  - result_o, valid_o and the internal state hold stable while ready_i=0.
  - On valid_o&&ready_i: go to IDLE. ready_o rises the next cycle; no same-cycle re-accept.
- Latency: valid_o asserts L=max(1,ceil(shamt/STEP)) cycles after the accepting edge.
  - Examples with STEP=4: shamt 0 → 1, 4 → 1, 5 → 2, 31 → 8.
- Arithmetic fill: the sign bit is the original data_i[WIDTH-1]. Repeated per-step fill from work[WIDTH-1] is equivalent and required.
- shamt is taken modulo WIDTH, so only the low SHW bits are used.
- Inputs are ignored outside IDLE. valid_i asserted during SHIFT/DONE is not accepted and not queued.
- result_o is driven from the work register and is checked only while valid_o=1.
- Reset asserted mid-operation (SHIFT or DONE): the operation is aborted immediately (asynchronous) and all outputs return to reset values. No result is produced for the aborted request.
- Output handshake: once asserted, valid_o never drops without ready_i.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shr_state_e;
  - localparam int XLEN = 32.
- Sub-module shift_right_step (combinational): inputs data, amount (0..STEP), fill bit; output shifted data.
  - Instantiated once in shift_right_seq.
  - Unit-testable standalone against >>>/>>.

Test Plan:
- SRL: data_i=0x8000_00F0, shamt_i=4, arith_i=0 → result_o=0x0800_000F, valid_o exactly 1 cycle after accept.
- SRA: data_i=0x8000_00F0, shamt_i=4, arith_i=1 → result_o=0xF800_000F. Same data with shamt_i=5 → 0xFC00_0007, latency 2.
- Boundaries:
  - shamt_i=0, data_i=0x1234_5678 → result_o=0x1234_5678, latency 1.
  - shamt_i=31, data_i=0x8000_0000: SRA → 0xFFFF_FFFF, SRL → 0x0000_0001, latency 8.
- Backpressure: hold ready_i=0 for 3 cycles in DONE → valid_o=1 and result_o stable; ready_o=0 throughout; a valid_i pulse in that window is not accepted. ready_i=1 → IDLE, ready_o=1 next cycle.
- Reset mid-shift:
  - Accept shamt_i=31, drop rst_ni low 3 cycles later → valid_o=0 and result_o=0 immediately; ready_o=1 after release.
  - A following request, data_i=0xFFFF_0000, shamt_i=16, SRL → 0x0000_FFFF.
- Random: 1000 back-to-back requests with random data/shamt/arith and random ready_i → every result matches the >>/>>> model; the latency formula holds.
